// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared widths and recovery FSM state type for the fault-tolerant recovery controller
package ft_pkg;

    localparam int FT_ADDR_WIDTH = 5;
    localparam int FT_DATA_WIDTH = 32;
    localparam int FT_CNT_WIDTH  = 8;
    localparam int FT_ERR_THRESHOLD = 4;
    localparam logic [31:0] FT_BOOT_ADDR = 32'h0000_0080;

    typedef enum logic [2:0] {
        REC_IDLE,
        REC_HALT,
        REC_RESTORE,
        REC_RESUME,
        REC_FATAL
    } rec_state_e;

endpackage

// File: rtl/ft_shadow_rf.sv
// rtl/ft_shadow_rf.sv - golden shadow register file, one sync write port (x0 masked), one comb read port
module ft_shadow_rf
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = FT_ADDR_WIDTH,
    parameter int DATA_WIDTH = FT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [NREGS];
    logic [DATA_WIDTH-1:0] mem_d [NREGS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i && (wr_addr_i != '0)) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ft_recovery_ctrl.sv
// rtl/ft_recovery_ctrl.sv - lockstep error recovery: shadow commit, halt, regfile restore, PC redirect, fatal escalation
module ft_recovery_ctrl
    import ft_pkg::*;
#(
    parameter int              ADDR_WIDTH    = FT_ADDR_WIDTH,
    parameter int              DATA_WIDTH    = FT_DATA_WIDTH,
    parameter int              CNT_WIDTH     = FT_CNT_WIDTH,
    parameter int              ERR_THRESHOLD = FT_ERR_THRESHOLD,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR = DATA_WIDTH'(FT_BOOT_ADDR)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_instr_i,
    input  logic                  error_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  halt_o,
    output logic                  recovering_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_data_o,
    output logic                  pc_restore_valid_o,
    output logic [DATA_WIDTH-1:0] pc_restore_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic                  fatal_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  THRESHOLD = CNT_WIDTH'(ERR_THRESHOLD);

    rec_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic                  commit_we;
    logic [DATA_WIDTH-1:0] shadow_rd_data;

    logic                  halt_q, halt_d;
    logic                  recovering_q, recovering_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
    logic                  pc_valid_q, pc_valid_d;
    logic [DATA_WIDTH-1:0] pc_restore_q, pc_restore_d;
    logic                  fatal_q, fatal_d;

    ft_shadow_rf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow_rf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (commit_we),
        .wr_addr_i (addr_i),
        .wr_data_i (data_i),
        .rd_addr_i (cnt_d),
        .rd_data_o (shadow_rd_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_pc_d = last_pc_q;
        err_d     = err_q;
        commit_we = 1'b0;
        case (state_q)
            REC_IDLE: begin
                if (valid_instr_i) begin
                    if (error_i) begin
                        err_d   = (err_q == CNT_MAX) ? err_q : err_q + CNT_WIDTH'(1);
                        state_d = (err_d >= THRESHOLD) ? REC_FATAL : REC_HALT;
                    end else begin
                        last_pc_d = pc_i;
                        commit_we = we_i;
                    end
                end
            end
            REC_HALT: begin
                state_d = REC_RESTORE;
                cnt_d   = ADDR_WIDTH'(1);
            end
            REC_RESTORE: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = REC_RESUME;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            REC_RESUME: state_d = REC_IDLE;
            REC_FATAL:  state_d = REC_FATAL;
            default:    state_d = REC_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        halt_d       = (state_d != REC_IDLE);
        recovering_d = (state_d == REC_HALT) || (state_d == REC_RESTORE) || (state_d == REC_RESUME);
        rf_we_d      = (state_d == REC_RESTORE);
        rf_addr_d    = rf_we_d ? cnt_d : '0;
        rf_data_d    = rf_we_d ? shadow_rd_data : '0;
        pc_valid_d   = (state_d == REC_RESUME);
        pc_restore_d = pc_valid_d ? last_pc_q : '0;
        fatal_d      = (state_d == REC_FATAL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= REC_IDLE;
            cnt_q        <= '0;
            last_pc_q    <= BOOT_ADDR;
            err_q        <= '0;
            halt_q       <= 1'b0;
            recovering_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
            pc_valid_q   <= 1'b0;
            pc_restore_q <= '0;
            fatal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_pc_q    <= last_pc_d;
            err_q        <= err_d;
            halt_q       <= halt_d;
            recovering_q <= recovering_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
            pc_valid_q   <= pc_valid_d;
            pc_restore_q <= pc_restore_d;
            fatal_q      <= fatal_d;
        end
    end

    assign halt_o             = halt_q;
    assign recovering_o       = recovering_q;
    assign rf_we_o            = rf_we_q;
    assign rf_addr_o          = rf_addr_q;
    assign rf_data_o          = rf_data_q;
    assign pc_restore_valid_o = pc_valid_q;
    assign pc_restore_o       = pc_restore_q;
    assign err_count_o        = err_q;
    assign fatal_o            = fatal_q;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb/tb_ft_recovery_ctrl.sv - randomized self-checking bench for ft_recovery_ctrl against a cycle-offset reference model
module tb_ft_recovery_ctrl;

    localparam int          AW   = 5;
    localparam int          DW   = 32;
    localparam int          CW   = 8;
    localparam int          THR  = 3;
    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_instr_i;
    logic          error_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] data_i;
    logic [DW-1:0] pc_i;
    logic          halt_o;
    logic          recovering_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_addr_o;
    logic [DW-1:0] rf_data_o;
    logic          pc_restore_valid_o;
    logic [DW-1:0] pc_restore_o;
    logic [CW-1:0] err_count_o;
    logic          fatal_o;

    always #5 clk_i = ~clk_i;

    ft_recovery_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .CNT_WIDTH     (CW),
        .ERR_THRESHOLD (THR),
        .BOOT_ADDR     (BOOT)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .valid_instr_i      (valid_instr_i),
        .error_i            (error_i),
        .we_i               (we_i),
        .addr_i             (addr_i),
        .data_i             (data_i),
        .pc_i               (pc_i),
        .halt_o             (halt_o),
        .recovering_o       (recovering_o),
        .rf_we_o            (rf_we_o),
        .rf_addr_o          (rf_addr_o),
        .rf_data_o          (rf_data_o),
        .pc_restore_valid_o (pc_restore_valid_o),
        .pc_restore_o       (pc_restore_o),
        .err_count_o        (err_count_o),
        .fatal_o            (fatal_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: m_k is the number of cycles since the detected error (0 = not recovering).
    logic [31:0] m_shadow [32];
    logic [31:0] m_pc;
    int          m_cnt;
    int          m_k;
    bit          m_fatal;
    bit          m_rst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input bit e, input bit w,
                              input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        m_rst = r;
        if (r) begin
            for (int i = 0; i < 32; i++) m_shadow[i] = '0;
            m_pc = BOOT; m_cnt = 0; m_k = 0; m_fatal = 0;
        end else if (m_fatal) begin
        end else if (m_k > 0) begin
            m_k++;
            if (m_k == 34) m_k = 0;
        end else if (v && e) begin
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            if (m_cnt >= THR) m_fatal = 1; else m_k = 1;
        end else if (v) begin
            m_pc = p;
            if (w && a != 0) m_shadow[a] = d;
        end
    endtask

    task automatic check_outputs();
        bit ewe, epv;
        ewe = (m_k >= 2) && (m_k <= 32);
        epv = (m_k == 33);
        check_eq("halt", 32'(halt_o), 32'(m_fatal || m_k > 0));
        check_eq("recovering", 32'(recovering_o), 32'(m_k > 0));
        check_eq("rf_we", 32'(rf_we_o), 32'(ewe));
        check_eq("pc_valid", 32'(pc_restore_valid_o), 32'(epv));
        check_eq("fatal", 32'(fatal_o), 32'(m_fatal));
        check_eq("err_count", 32'(err_count_o), 32'(m_cnt));
        if (ewe) begin
            check_eq("rf_addr", 32'(rf_addr_o), 32'(m_k - 1));
            check_eq("rf_data", rf_data_o, m_shadow[m_k - 1]);
        end
        if (epv) check_eq("pc_restore", pc_restore_o, m_pc);
        if (m_rst) begin
            check_eq("rst_rf_addr", 32'(rf_addr_o), 32'h0);
            check_eq("rst_rf_data", rf_data_o, 32'h0);
            check_eq("rst_pc_restore", pc_restore_o, 32'h0);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit e, input bit w,
                         input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        rst_i = r; valid_instr_i = v; error_i = e; we_i = w;
        addr_i = a; data_i = d; pc_i = p;
        @(posedge clk_i);
        model_step(r, v, e, w, a, d, p);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic rand_cycle(input int err_pct);
        bit v, e;
        v = 1'($urandom_range(0, 1));
        e = ($urandom_range(0, 99) < err_pct);
        cycle(1'b0, v, e, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom);
    endtask

    initial begin
        int guard;
        int fatal_cycles;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);

        // x0 commit is masked; then addr5 commit with pc 0x100
        cycle(0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF, 32'h0000_00FC);
        cycle(0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0100);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // error without valid is ignored
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 5'd7, 32'h1234_5678, 32'h200);

        // detected error, then noisy inputs (errors and commits) during recovery
        cycle(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) cycle(0, 1, 1'(i % 2), 1, 5'($urandom), $urandom, $urandom);
        check_eq("restored_pc", m_pc, 32'h0000_0100);

        // reset mid-restore while rf_addr_o shows 10
        cycle(0, 1, 0, 1, 5'd9, 32'hCAFE_0009, 32'h300);
        cycle(0, 1, 0, 1, 5'd10, 32'hCAFE_000A, 32'h304);
        cycle(0, 1, 1, 0, 0, 0, 0);
        guard = 0;
        while (m_k != 11 && guard < 40) begin
            rand_cycle(50);
            guard++;
        end
        check_eq("reached_addr10", 32'(m_k), 32'd11);
        cycle(1, 1, 1, 1, 5'd3, 32'h5555_5555, 32'h400);
        cycle(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 34; i++) rand_cycle(30);

        // random traffic; fatal escalation is held then cleared by reset
        fatal_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_fatal) begin
                fatal_cycles++;
                if (fatal_cycles > 6) begin
                    cycle(1, 0, 0, 0, 0, 0, 0);
                    fatal_cycles = 0;
                end else begin
                    rand_cycle(50);
                end
            end else if ($urandom_range(0, 799) == 0) begin
                cycle(1, 1, 1, 1, 5'($urandom), $urandom, $urandom);
            end else begin
                rand_cycle(3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
